// File: rtl/time_set_pkg.sv
// Shared definitions for the time/alarm entry controller: FSM encoding,
// edit_field codes and BCD digit limits.
package time_set_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEL_TGT  = 3'd1,
    ST_EDIT_HR  = 3'd2,
    ST_EDIT_MIN = 3'd3,
    ST_COMMIT   = 3'd4
  } state_t;

  localparam logic [1:0] EF_NONE = 2'd0;
  localparam logic [1:0] EF_HOUR = 2'd1;
  localparam logic [1:0] EF_MIN  = 2'd2;
  localparam logic [1:0] EF_TGT  = 2'd3;

  localparam int unsigned HR_MAX  = 23;
  localparam int unsigned MIN_MAX = 59;

  localparam logic [1:0] HR_MAX_T  = 2'(HR_MAX / 10);
  localparam logic [3:0] HR_MAX_U  = 4'(HR_MAX % 10);
  localparam logic [3:0] MIN_MAX_T = 4'(MIN_MAX / 10);
  localparam logic [3:0] MIN_MAX_U = 4'(MIN_MAX % 10);

  // Field indicator shown to the user for a given state
  function automatic logic [1:0] field_of(input state_t s);
    case (s)
      ST_EDIT_HR:  field_of = EF_HOUR;
      ST_EDIT_MIN: field_of = EF_MIN;
      ST_SEL_TGT:  field_of = EF_TGT;
      default:     field_of = EF_NONE;
    endcase
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Per-button debouncer: 2-flop synchronizer, stability counter and a
// one-cycle registered press pulse on an accepted 0->1 level change.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int unsigned CW = 8;

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CW-1:0]    cnt;

  // Synchronize, count disagreeing samples, accept level after DEB_CYCLES
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
        press  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time/alarm entry controller feeding alarm_clock.
// Optional feature macro: TIME_SET_ALARM_EN (adds target selection and
// the LD_alarm path; without it target and LD_alarm are held at 0).
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_set,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic [1:0] edit_field,
  output logic       target
);

  logic mode_ev;
  logic inc_ev;
  logic set_ev;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk(clk), .reset(reset), .raw(btn_mode), .press(mode_ev));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk(clk), .reset(reset), .raw(btn_inc), .press(inc_ev));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .clk(clk), .reset(reset), .raw(btn_set), .press(set_ev));

  state_t     state;
  state_t     state_d;
  logic [1:0] h1_d;
  logic [3:0] h0_d;
  logic [3:0] m1_d;
  logic [3:0] m0_d;
`ifdef TIME_SET_ALARM_EN
  logic       target_d;
`endif

  // Next state and digit stepping; priority set > mode > inc
  always_comb begin
    state_d = state;
    h1_d    = H_in1;
    h0_d    = H_in0;
    m1_d    = M_in1;
    m0_d    = M_in0;
`ifdef TIME_SET_ALARM_EN
    target_d = target;
`endif
    case (state)
      ST_IDLE: begin
        if (!set_ev && mode_ev) begin
`ifdef TIME_SET_ALARM_EN
          state_d = ST_SEL_TGT;
`else
          state_d = ST_EDIT_HR;
`endif
        end
      end
`ifdef TIME_SET_ALARM_EN
      ST_SEL_TGT: begin
        if (set_ev)       state_d  = ST_COMMIT;
        else if (mode_ev) state_d  = ST_EDIT_HR;
        else if (inc_ev)  target_d = ~target;
      end
`endif
      ST_EDIT_HR: begin
        if (set_ev) begin
          state_d = ST_COMMIT;
        end else if (mode_ev) begin
          state_d = ST_EDIT_MIN;
        end else if (inc_ev) begin
          if (H_in1 == HR_MAX_T && H_in0 == HR_MAX_U) begin
            h1_d = 2'd0;
            h0_d = 4'd0;
          end else if (H_in0 == 4'd9) begin
            h0_d = 4'd0;
            h1_d = H_in1 + 2'd1;
          end else begin
            h0_d = H_in0 + 4'd1;
          end
        end
      end
      ST_EDIT_MIN: begin
        if (set_ev) begin
          state_d = ST_COMMIT;
        end else if (mode_ev) begin
          state_d = ST_EDIT_HR;
        end else if (inc_ev) begin
          if (M_in1 == MIN_MAX_T && M_in0 == MIN_MAX_U) begin
            m1_d = 4'd0;
            m0_d = 4'd0;
          end else if (M_in0 == 4'd9) begin
            m0_d = 4'd0;
            m1_d = M_in1 + 4'd1;
          end else begin
            m0_d = M_in0 + 4'd1;
          end
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, digits and registered outputs derived from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      H_in1      <= 2'd0;
      H_in0      <= 4'd0;
      M_in1      <= 4'd0;
      M_in0      <= 4'd0;
      LD_time    <= 1'b0;
      LD_alarm   <= 1'b0;
      edit_field <= EF_NONE;
      target     <= 1'b0;
    end else begin
      state      <= state_d;
      H_in1      <= h1_d;
      H_in0      <= h0_d;
      M_in1      <= m1_d;
      M_in0      <= m0_d;
      edit_field <= field_of(state_d);
`ifdef TIME_SET_ALARM_EN
      target     <= target_d;
      LD_time    <= (state_d == ST_COMMIT) && !target_d;
      LD_alarm   <= (state_d == ST_COMMIT) && target_d;
`else
      target     <= 1'b0;
      LD_time    <= (state_d == ST_COMMIT);
      LD_alarm   <= 1'b0;
`endif
    end
  end

endmodule
